// File: rtl/draw_scheduler.sv
// Block-draw scheduler: queues cell draw/erase requests in a small FIFO and sequences
// the datapath through UPDATE/DRAW per block, with sticky win/lose screen requests.
module draw_scheduler #(
  parameter int DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_x,
  input  logic [3:0] req_y,
  input  logic       req_erase,
  input  logic       win_req,
  input  logic       lose_req,
  input  logic       screen_done,
  output logic [3:0] x_out,
  output logic [3:0] y_out,
  output logic       update,
  output logic       draw_game,
  output logic       erase,
  output logic       draw_win,
  output logic       draw_lose,
  output logic       plot,
  output logic       busy,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_DRAW, S_SCREEN} state_t;

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  state_t          state;
  logic [8:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [8:0]      head;
  logic [8:0]      draw_idx;
  logic            win_pend;
  logic            lose_pend;
  logic            cell_erase;
  logic            push;
  logic            pop;
  logic            enter_win;
  logic            enter_lose;

  // Request handshake: a request transfers on a rising edge where req_valid and
  // req_ready are both high; req_ready depends only on FIFO occupancy, never on req_valid.
  assign req_ready  = (count != FULL);
  assign push       = req_valid && req_ready;
  assign head       = mem[rd_ptr];
  assign enter_win  = (state == S_IDLE) && win_pend;
  assign enter_lose = (state == S_IDLE) && !win_pend && lose_pend;
  assign pop        = (state == S_IDLE) && !win_pend && !lose_pend && (count != '0);
  assign state_dbg  = state;

  always_ff @(posedge clock) begin
    if (!reset && push) mem[wr_ptr] <= {req_x, req_y, req_erase};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      win_pend   <= 1'b0;
      lose_pend  <= 1'b0;
      draw_idx   <= '0;
      cell_erase <= 1'b0;
      x_out      <= '0;
      y_out      <= '0;
      update     <= 1'b0;
      draw_game  <= 1'b0;
      erase      <= 1'b0;
      draw_win   <= 1'b0;
      draw_lose  <= 1'b0;
      plot       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      // A fresh pulse in the entry cycle is kept so it is serviced again later.
      win_pend  <= (win_pend && !enter_win) || win_req;
      lose_pend <= (lose_pend && !enter_lose) || lose_req;

      // Outputs are registered: each transition loads the controls of the next state.
      case (state)
        S_IDLE: begin
          if (enter_win) begin
            state    <= S_SCREEN;
            draw_win <= 1'b1;
            busy     <= 1'b1;
          end else if (enter_lose) begin
            state     <= S_SCREEN;
            draw_lose <= 1'b1;
            busy      <= 1'b1;
          end else if (pop) begin
            state      <= S_UPDATE;
            x_out      <= head[8:5];
            y_out      <= head[4:1];
            cell_erase <= head[0];
            update     <= 1'b1;
            busy       <= 1'b1;
          end
        end
        S_UPDATE: begin
          state     <= S_DRAW;
          update    <= 1'b0;
          draw_idx  <= '0;
          draw_game <= !cell_erase;
          erase     <= cell_erase;
          plot      <= 1'b0;
        end
        S_DRAW: begin
          if (draw_idx == 9'd256) begin
            state     <= S_IDLE;
            draw_idx  <= '0;
            draw_game <= 1'b0;
            erase     <= 1'b0;
            plot      <= 1'b0;
            busy      <= 1'b0;
          end else begin
            draw_idx <= draw_idx + 1'b1;
            plot     <= 1'b1;
          end
        end
        S_SCREEN: begin
          if (screen_done) begin
            state     <= S_IDLE;
            draw_win  <= 1'b0;
            draw_lose <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_draw_scheduler.sv
// Bench for draw_scheduler: directed scenarios plus random traffic, every cycle compared
// against a job/age reference model of the scheduler.
module tb_draw_scheduler;

  localparam int DEPTH = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_x;
  logic [3:0] req_y;
  logic       req_erase;
  logic       win_req;
  logic       lose_req;
  logic       screen_done;
  logic [3:0] x_out;
  logic [3:0] y_out;
  logic       update;
  logic       draw_game;
  logic       erase;
  logic       draw_win;
  logic       draw_lose;
  logic       plot;
  logic       busy;
  logic [1:0] state_dbg;

  draw_scheduler #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_erase(req_erase), .win_req(win_req),
    .lose_req(lose_req), .screen_done(screen_done), .x_out(x_out), .y_out(y_out),
    .update(update), .draw_game(draw_game), .erase(erase), .draw_win(draw_win),
    .draw_lose(draw_lose), .plot(plot), .busy(busy), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: a job (0 none, 1 block, 2 win screen, 3 lose screen) and the
  // age of a block job: age 0 is the update cycle, ages 1..257 the draw cycles.
  logic [8:0] m_q[$];
  int         m_job = 0;
  int         m_age = 0;
  logic       m_wp = 1'b0;
  logic       m_lp = 1'b0;
  logic [3:0] m_x = '0;
  logic [3:0] m_y = '0;
  logic       m_er = 1'b0;

  // scoreboard: expected order of job starts (1 block, 2 win, 3 lose)
  logic [1:0] exp_q[$];
  logic [1:0] ev_q[$];
  int         plot_cnt = 0;
  int         dg_cnt = 0;
  int         accepted = 0;
  logic       prev_upd = 1'b0;
  logic       prev_win = 1'b0;
  logic       prev_lose = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic model_step();
    logic [8:0] head;
    logic       ready_now;
    logic       ent_w;
    logic       ent_l;
    if (reset) begin
      m_q.delete();
      m_job = 0; m_age = 0; m_wp = 1'b0; m_lp = 1'b0;
      m_x = '0; m_y = '0; m_er = 1'b0;
      return;
    end
    ready_now = (m_q.size() < DEPTH);
    ent_w = 1'b0;
    ent_l = 1'b0;
    case (m_job)
      0: begin
        if (m_wp) begin
          m_job = 2; ent_w = 1'b1;
        end else if (m_lp) begin
          m_job = 3; ent_l = 1'b1;
        end else if (m_q.size() > 0) begin
          head = m_q.pop_front();
          m_x = head[8:5]; m_y = head[4:1]; m_er = head[0];
          m_job = 1; m_age = 0;
        end
      end
      1: begin
        if (m_age == 257) m_job = 0;
        else m_age++;
      end
      default: if (screen_done) m_job = 0;
    endcase
    if (req_valid && ready_now) m_q.push_back({req_x, req_y, req_erase});
    m_wp = (m_wp && !ent_w) || win_req;
    m_lp = (m_lp && !ent_l) || lose_req;
  endtask

  function automatic logic [15:0] model_outs();
    logic blk;
    blk = (m_job == 1);
    return {m_job != 0, blk && m_age == 0, blk && m_age >= 1 && !m_er,
            blk && m_age >= 1 && m_er, m_job == 2, m_job == 3, blk && m_age >= 2,
            m_q.size() < DEPTH, m_x, m_y};
  endfunction

  // driver: one clock cycle with inputs as currently set; outputs sampled 1 time unit later
  task automatic tick();
    logic [15:0] got;
    screen_done = ($urandom_range(0, 7) == 0);
    if (req_valid && req_ready && !reset) accepted++;
    @(posedge clock);
    model_step();
    #1;
    got = {busy, update, draw_game, erase, draw_win, draw_lose, plot, req_ready, x_out, y_out};
    check("outs", got, model_outs());
    if (update && !prev_upd) ev_q.push_back(2'd1);
    if (draw_win && !prev_win) ev_q.push_back(2'd2);
    if (draw_lose && !prev_lose) ev_q.push_back(2'd3);
    prev_upd = update; prev_win = draw_win; prev_lose = draw_lose;
    if (plot) plot_cnt++;
    if (draw_game) dg_cnt++;
  endtask

  task automatic push_req(input logic [3:0] x, input logic [3:0] y, input logic e);
    req_valid = 1'b1; req_x = x; req_y = y; req_erase = e;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max, input string tag);
    int n = 0;
    while (!(busy == 1'b0 && m_job == 0 && m_q.size() == 0 && !m_wp && !m_lp) && n < max) begin
      tick();
      n++;
    end
    check(tag, n < max, 1);
  endtask

  task automatic wait_update(input int max, input string tag);
    int n = 0;
    while (!update && n < max) begin
      tick();
      n++;
    end
    check(tag, n < max, 1);
  endtask

  task automatic check_order(input string tag);
    for (int i = 0; i < exp_q.size(); i++)
      check(tag, (i < ev_q.size()) ? ev_q[i] : 2'd0, exp_q[i]);
    check({tag, "_len"}, ev_q.size(), exp_q.size());
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_x = '0; req_y = '0; req_erase = 1'b0;
    win_req = 1'b0; lose_req = 1'b0; screen_done = 1'b0;

    // reset, with a request presented that must be discarded
    tick();
    req_valid = 1'b1; req_x = 4'd9; req_y = 4'd9;
    tick();
    req_valid = 1'b0; reset = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_ready", req_ready, 1);
    check("rst_xy", {x_out, y_out}, 8'h00);
    check("rst_ctrl", {update, draw_game, erase, draw_win, draw_lose, plot}, 6'b0);
    repeat (3) tick();
    check("rst_discard", busy, 0);

    // single draw
    ev_q.delete(); plot_cnt = 0; dg_cnt = 0;
    push_req(4'd3, 4'd5, 1'b0);
    wait_update(5, "single_upd_to");
    check("single_xy", {x_out, y_out}, 8'h35);
    wait_idle(600, "single_to");
    check("single_plots", plot_cnt, 256);
    check("single_dg", dg_cnt, 257);
    check("single_busy", busy, 0);

    // fill / overflow while a draw blocks the FIFO
    push_req(4'd1, 4'd1, 1'b0);
    wait_update(5, "ovf_upd_to");
    accepted = 0;
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_x = 4'(i + 2); req_y = 4'(12 - i); req_erase = i[0];
      tick();
    end
    req_valid = 1'b0;
    check("ovf_accepted", accepted, 4);
    check("ovf_ready", req_ready, 0);
    ev_q.delete();
    wait_idle(3000, "ovf_to");
    exp_q = '{2'd1, 2'd1, 2'd1, 2'd1};
    check_order("ovf_order");

    // win priority over lose, both ahead of queued draws
    push_req(4'd2, 4'd2, 1'b0);
    wait_update(5, "prio_upd_to");
    push_req(4'd4, 4'd4, 1'b1);
    push_req(4'd6, 4'd6, 1'b0);
    ev_q.delete();
    win_req = 1'b1; lose_req = 1'b1;
    tick();
    win_req = 1'b0; lose_req = 1'b0;
    wait_idle(3000, "prio_to");
    exp_q = '{2'd2, 2'd3, 2'd1, 2'd1};
    check_order("prio_order");

    // lose request in the middle of a draw
    plot_cnt = 0;
    push_req(4'd7, 4'd9, 1'b1);
    wait_update(5, "mid_upd_to");
    ev_q.delete();
    repeat (101) tick();
    lose_req = 1'b1;
    tick();
    lose_req = 1'b0;
    wait_idle(1000, "mid_to");
    check("mid_plots", plot_cnt, 256);
    exp_q = '{2'd3};
    check_order("mid_order");

    // reset in the middle of a draw drops queued work
    push_req(4'd1, 4'd2, 1'b0);
    wait_update(5, "rmd_upd_to");
    push_req(4'd3, 4'd3, 1'b0);
    repeat (49) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rmd_busy", busy, 0);
    check("rmd_plot", plot, 0);
    check("rmd_ready", req_ready, 1);
    ev_q.delete(); plot_cnt = 0;
    repeat (20) tick();
    check("rmd_lost", ev_q.size(), 0);
    check("rmd_noplot", plot_cnt, 0);

    // pointer wrap: ten blocks one at a time
    ev_q.delete();
    for (int i = 0; i < 10; i++) begin
      push_req(4'(i), 4'(15 - i), (i % 3) == 0);
      wait_update(5, "wrap_upd_to");
      check("wrap_xy", {x_out, y_out}, {4'(i), 4'(15 - i)});
      wait_idle(600, "wrap_to");
    end
    check("wrap_blocks", ev_q.size(), 10);

    // random traffic
    for (int n = 0; n < 4000; n++) begin
      req_valid = ($urandom_range(0, 15) == 0);
      req_x = 4'($urandom_range(0, 15));
      req_y = 4'($urandom_range(0, 15));
      req_erase = 1'($urandom_range(0, 1));
      win_req = ($urandom_range(0, 199) == 0);
      lose_req = ($urandom_range(0, 199) == 0);
      reset = ($urandom_range(0, 999) == 0);
      tick();
    end
    req_valid = 1'b0; win_req = 1'b0; lose_req = 1'b0; reset = 1'b0;
    wait_idle(5000, "rand_drain_to");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
